// File: rtl/solomon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : solomon_pkg
//  Description : Shared error codes, loader state type and index helper for
//                the ROM download sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package solomon_pkg;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_GAP   = 2'b01;
    localparam logic [1:0] c_ERR_OVF   = 2'b10;
    localparam logic [1:0] c_ERR_SHORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_TAIL = 3'd2,
        ST_RUN  = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    // Width of a region index; a single region still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rom_region_decode
//  Description : Maps a flat download address onto a ROM region index and a
//                region-local offset using ascending region base addresses.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_region_decode
    import solomon_pkg::*;
#(
    parameter int                 NREG  = 4,
    parameter int                 AW    = 25,
    parameter logic [NREG*AW-1:0] RBASE = {25'h0C000, 25'h08000, 25'h04000, 25'h0}
) (
    input  logic [AW-1:0]              i_addr,
    output logic [idx_width(NREG)-1:0] o_region,
    output logic [AW-1:0]              o_offset
);

    localparam int c_IW = idx_width(NREG);

    // Bases ascend, so the last match in the scan is the highest region.
    always_comb begin
        o_region = '0;
        o_offset = i_addr;
        for (int r = 1; r < NREG; r++) begin
            if (i_addr >= RBASE[r*AW +: AW]) begin
                o_region = c_IW'(r);
                o_offset = i_addr - RBASE[r*AW +: AW];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_load_sequencer
//  Description : Steers the HPS ioctl byte stream into the ROM region RAMs and
//                releases the game core only after a complete, gap-free image.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_load_sequencer
    import solomon_pkg::*;
#(
    parameter int                 NREG  = 4,
    parameter int                 AW    = 25,
    parameter logic [NREG*AW-1:0] RBASE = {25'h0C000, 25'h08000, 25'h04000, 25'h0},
    parameter logic [AW-1:0]      TOTAL = 25'h10000,
    parameter int                 TAIL  = 1024
) (
    input  logic            MCLK,
    input  logic            RESET_N,
    input  logic            DL,
    input  logic            ROMEN,
    input  logic [AW-1:0]   ROMAD,
    input  logic [7:0]      ROMDT,
    output logic [NREG-1:0] WE,
    output logic [AW-1:0]   WAD,
    output logic [7:0]      WDT,
    output logic            PORT_SEL,
    output logic            CORE_RST,
    output logic            LOADED,
    output logic [1:0]      ERR,
    output logic [AW-1:0]   BCNT
);

    localparam int c_IW = idx_width(NREG);
    localparam int c_TW = $clog2(TAIL + 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_dl_q;
    logic [c_TW-1:0] r_tcnt;

    logic [c_IW-1:0] w_region;
    logic [AW-1:0]   w_offset;
    logic [AW-1:0]   w_cnt;
    logic            w_dl_rise, w_start, w_in_load;
    logic            w_ovf, w_gap, w_acc, w_end, w_tail_done;
    logic            w_port_sel_d, w_core_rst_d, w_loaded_d;
    logic [1:0]      w_err_d;

    rom_region_decode #(
        .NREG  (NREG),
        .AW    (AW),
        .RBASE (RBASE)
    ) u_decode (
        .i_addr   (ROMAD),
        .o_region (w_region),
        .o_offset (w_offset)
    );

    // The cycle that starts a load is treated as a load cycle with a zero
    // count, so a byte 0 arriving alongside the DL rise is not lost.
    assign w_dl_rise   = DL & ~r_dl_q;
    assign w_start     = (r_state == ST_IDLE) ? DL : ((r_state != ST_LOAD) & w_dl_rise);
    assign w_in_load   = (r_state == ST_LOAD) | w_start;
    assign w_cnt       = w_start ? '0 : BCNT;
    assign w_ovf       = w_in_load & ROMEN & (ROMAD >= TOTAL);
    assign w_gap       = w_in_load & ROMEN & (ROMAD < TOTAL) & (ROMAD != w_cnt);
    assign w_acc       = w_in_load & ROMEN & (ROMAD < TOTAL) & (ROMAD == w_cnt);
    assign w_end       = w_in_load & ~ROMEN & ~DL;
    assign w_tail_done = (r_state == ST_TAIL) & ~w_dl_rise & (r_tcnt == c_TW'(TAIL - 1));

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_dl_q  <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_dl_q  <= DL;
            r_tcnt  <= (r_state == ST_TAIL) ? r_tcnt + c_TW'(1) : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_in_load) begin
            if (w_ovf | w_gap) begin
                w_next = ST_FAIL;
            end else if (w_end) begin
                w_next = (w_cnt == TOTAL) ? ST_TAIL : ST_FAIL;
            end else begin
                w_next = ST_LOAD;
            end
        end else if (w_tail_done) begin
            w_next = ST_RUN;
        end
    end

    // Ports go to the core on entry to RUN; reset drops only once RUN is
    // already established, giving the one-cycle handover gap.
    always_comb begin
        w_port_sel_d = (w_next != ST_RUN);
        w_core_rst_d = !((r_state == ST_RUN) && (w_next == ST_RUN));
        w_loaded_d   = LOADED;
        w_err_d      = ERR;
        if (w_start) begin
            w_loaded_d = 1'b0;
            w_err_d    = c_ERR_OK;
        end
        if (w_tail_done) begin
            w_loaded_d = 1'b1;
        end
        if (w_ovf) begin
            w_err_d = c_ERR_OVF;
        end else if (w_gap) begin
            w_err_d = c_ERR_GAP;
        end else if (w_end && (w_cnt != TOTAL)) begin
            w_err_d = c_ERR_SHORT;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WE       <= '0;
            WAD      <= '0;
            WDT      <= '0;
            PORT_SEL <= 1'b1;
            CORE_RST <= 1'b1;
            LOADED   <= 1'b0;
            ERR      <= c_ERR_OK;
            BCNT     <= '0;
        end else begin
            WE <= w_acc ? (NREG'(1) << w_region) : '0;
            if (w_acc) begin
                WAD <= w_offset;
                WDT <= ROMDT;
            end
            BCNT     <= (w_acc && (w_cnt != TOTAL)) ? w_cnt + AW'(1) : w_cnt;
            PORT_SEL <= w_port_sel_d;
            CORE_RST <= w_core_rst_d;
            LOADED   <= w_loaded_d;
            ERR      <= w_err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sequences the HPS ROM download stream (ioctl byte writes) into the game core's ROM regions.
- Decodes the flat download address into per-region write strobes and region-local addresses.
- Owns the region RAM write ports during loading, then hands them to the core.
- Holds the game core in reset until a complete, gap-free image has been loaded plus a settle tail.

Parameters:
- NREG, 4, number of ROM regions (1..8).
- AW, 25, download address width.
- RBASE, {25'h0C000,25'h08000,25'h04000,25'h0}, packed NREG*AW region base addresses; region 0 base is 0; strictly ascending with index.
- TOTAL, 25'h10000, expected image length in bytes; end of the last region.
- TAIL, 1024, MCLK cycles that core reset is held after a good load.

Ports:
- MCLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- DL  in  1  download active (ioctl_download).
- ROMEN  in  1  byte write strobe, one cycle per byte.
- ROMAD  in  AW  flat download address.
- ROMDT  in  8  download byte.
- WE  out  NREG  one-hot region write strobe.
- WAD  out  AW  region-local address (ROMAD - RBASE[r]).
- WDT  out  8  registered byte.
- PORT_SEL  out  1  1 = loader owns the region RAM ports; 0 = core owns them.
- CORE_RST  out  1  active-high reset to the game core.
- LOADED  out  1  last load completed good.
- ERR  out  2  00 ok, 01 gap/out-of-order, 10 overflow (address >= TOTAL), 11 short image.
- BCNT  out  AW  bytes accepted in current/last load.

Behaviour:
- Async reset: state IDLE; WE=0, WAD=0, WDT=0, PORT_SEL=1, CORE_RST=1, LOADED=0, ERR=00, BCNT=0.
- States: IDLE, LOAD, TAIL, RUN, FAIL.
- IDLE: DL=1 -> LOAD; clear BCNT and ERR, set LOADED=0.
- LOAD:
  - Accepted write: ROMEN=1 and ROMAD==BCNT and ROMAD<TOTAL.
  - Region r is the highest index with RBASE[r] <= ROMAD.
  - The cycle after an accepted write: WE[r]=1 for exactly one cycle, WAD and WDT registered from that write; BCNT increments. Latency 1 cycle.
  - ROMEN with ROMAD != BCNT: no WE; ERR=01 -> FAIL.
  - ROMEN with ROMAD >= TOTAL: no WE; ERR=10 -> FAIL.
  - DL falls with BCNT==TOTAL -> TAIL.
  - DL falls with BCNT<TOTAL: ERR=11 -> FAIL.
- TAIL:
  - Counter runs TAIL cycles; then PORT_SEL=0 and LOADED=1, and CORE_RST falls on the following cycle -> RUN.
  - PORT_SEL drops one cycle before CORE_RST so the core never runs with the ports on the loader.
  - DL rising -> LOAD (restart).
- RUN: CORE_RST=0, PORT_SEL=0. DL rising -> PORT_SEL=1 and CORE_RST=1 in the same cycle -> LOAD.
- FAIL: CORE_RST=1, PORT_SEL=1, LOADED=0; ERR held. DL rising edge -> LOAD (clears ERR). ROMEN ignored.
- DL rising is edge-detected with a 1-cycle register.
- ROMEN in the same cycle that DL rises is accepted as the first byte if ROMAD==0.
- WE is never asserted outside LOAD; at most one WE bit is high in any cycle.
- BCNT saturates at TOTAL; it never wraps.
- RESET_N asserted mid-LOAD aborts to IDLE with all outputs at their reset values; the image is not marked good.

Decomposition:
- Shared package (solomon_pkg): ERR code constants and a state enum typedef.
- One sub-module, rom_region_decode: combinational ROMAD -> {region index, local offset} from RBASE. It is kept separate so other arcade cores can reuse it.
- The FSM, counters and strobe registers live in the top.

Test Plan:
- Good load: DL=1, bytes 0..0xFFFF in order, then DL=0 -> exactly 65536 WE pulses, 16384 per region. Byte 0x4000 produces WE=0010 with WAD=0. CORE_RST falls 1025 cycles after DL falls; LOADED=1; ERR=00.
- Gap: bytes 0..9, then addr 11 -> no WE for addr 11; ERR=01; FAIL; CORE_RST stays 1. A new DL rise with a good load -> RUN.
- Overflow: good load, then ROMEN at 0x10000 before DL falls -> no WE; ERR=10.
- Short image: DL falls at BCNT=0x8000 -> ERR=11; LOADED=0; PORT_SEL=1.
- Reload: DL rises while in RUN -> PORT_SEL=1 and CORE_RST=1 on the same edge; BCNT cleared; second good load -> RUN.
- Reset mid-load: RESET_N=0 at BCNT=0x1234 -> all outputs at reset values immediately (async); after release, state IDLE and CORE_RST=1.
